// File: rtl/riscproc_pkg.sv
// Shared definitions for the 4-bit-opcode RISC pipeline: opcodes, default widths
// and the instruction-fetch state encoding.
package riscproc_pkg;

   localparam int INSTR_W_DEF = 16;
   localparam int PC_W_DEF    = 8;

   localparam logic [3:0] OPC_ALU  = 4'b0000;
   localparam logic [3:0] OPC_ST   = 4'b0001;
   localparam logic [3:0] OPC_ALUI = 4'b0011;
   localparam logic [3:0] OPC_ALU2 = 4'b0111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack read bus; the fetch stage is the master.
interface if_fetch_stage_if #(
   parameter int INSTR_W = 16,
   parameter int PC_W    = 8
);
   logic               req;
   logic [PC_W-1:0]    addr;
   logic               ack;
   logic [INSTR_W-1:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry instruction+PC holding buffer used while decode is stalled.
module if_skid_buf #(
   parameter int INSTR_W = 16,
   parameter int PC_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               unload_i,
   input  logic               clear_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [PC_W-1:0]    pc_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [PC_W-1:0]    pc_o,
   output logic               full_o
);
   logic               full_q;
   logic [INSTR_W-1:0] instr_q;
   logic [PC_W-1:0]    pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q <= 1'b1;
      end else if (unload_i) begin
         full_q <= 1'b0;
      end
   end

   // NOTE: payload flops carry no reset; full_q alone decides whether they mean anything.
   always_ff @(posedge clk) begin
      if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign full_o  = full_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, reads instruction memory over req/ack and fills IF/ID.
// Optional perf counters (fetch_cnt, stall_cnt) are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage
   import riscproc_pkg::*;
#(
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   if_fetch_stage_if.master   imem,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic [3:0]         opcode
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0]        fetch_cnt,
   output logic [15:0]        stall_cnt
`endif
);
   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
   logic               ifid_valid_q, ifid_valid_d;

   logic               skid_load, skid_unload, skid_clear, skid_full;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;

   if_skid_buf #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (skid_clear),
      .instr_i  (imem.rdata),
      .pc_i     (pc_q),
      .instr_o  (skid_instr),
      .pc_o     (skid_pc),
      .full_o   (skid_full)
   );

   // DRAIN replays the address of the abandoned request so the bus never sees it move mid-request.
   assign imem.req  = (state_q == FETCH) || (state_q == DRAIN);
   assign imem.addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      skid_load    = 1'b0;
      skid_unload  = 1'b0;
      skid_clear   = 1'b0;

      if (flush) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = '0;
         skid_clear   = 1'b1;
         pc_d         = redirect_pc;
         if (imem.req && !imem.ack) begin
            state_d      = DRAIN;
            drain_addr_d = imem.addr;
         end else begin
            state_d = FETCH;
         end
      end else begin
         unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
               if (imem.ack) begin
                  pc_d = pc_q + 1'b1;
                  if (stall) begin
                     skid_load = 1'b1;
                     state_d   = HOLD;
                  end else begin
                     ifid_instr_d = imem.rdata;
                     ifid_pc_d    = pc_q;
                     ifid_valid_d = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  ifid_instr_d = skid_instr;
                  ifid_pc_d    = skid_pc;
                  ifid_valid_d = skid_full;
                  skid_unload  = 1'b1;
                  state_d      = FETCH;
               end
            end
            DRAIN: if (imem.ack) state_d = FETCH;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_valid = ifid_valid_q;
   assign opcode     = ifid_instr_q[INSTR_W-1 -: 4];

`ifdef IF_PERF_CNT_EN
   logic        load_fire;
   logic [15:0] fetch_cnt_q, stall_cnt_q;

   assign load_fire = !flush && !stall &&
                      (((state_q == FETCH) && imem.ack) || ((state_q == HOLD) && skid_full));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (load_fire && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (stall && ifid_valid_q && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 4-bit-opcode RISC pipeline; producer side of the opcode interface that the ID-stage control decoder consumes.
- Owns the PC and issues req/ack reads to instruction memory.
- Holds one instruction in a skid buffer under stall and drives the IF/ID pipeline register (instr, pc, valid, opcode) toward decode.

Parameters:
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4].
- PC_W, 8, PC/address width; word-addressed, PC increments by 1.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_W  fetch address; stable while imem_req=1.
- imem_ack  input  1  read data valid this cycle; sampled only while imem_req=1.
- imem_rdata  input  INSTR_W  fetched instruction.
- stall  input  1  hazard unit: hold PC and IF/ID (PCWrite=IFIDWrite=0).
- flush  input  1  squash IF/ID and redirect fetch.
- redirect_pc  input  PC_W  new PC, used when flush=1.
- ifid_instr  output  INSTR_W  IF/ID instruction.
- ifid_pc  output  PC_W  PC of ifid_instr.
- ifid_valid  output  1  IF/ID holds a live instruction; decode gates MW/EnRW with it.
- opcode  output  4  ifid_instr[INSTR_W-1 -: 4], combinational from the register.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0, opcode=0, skid empty, state=IDLE.
- First request is issued the cycle after rst_n deasserts.
- States:
  - IDLE: go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc.
    - On ack with stall=0: IF/ID<=rdata/pc, valid=1, pc<=pc+1, stay in FETCH. Back-to-back: new address the next cycle, so 1 instruction/cycle with zero-wait memory.
    - On ack with stall=1: rdata->skid, pc<=pc+1, go to HOLD.
  - HOLD: imem_req=0; when stall=0, IF/ID<=skid, skid empty, go to FETCH.
  - DRAIN: imem_req=1 with the old address until ack; data discarded; then pc=redirect value, go to FETCH.
- Fetch latency: IF/ID updates on the edge where ack=1; decode sees the new opcode that cycle plus clock-to-q.
- Stall: IF/ID, ifid_pc and ifid_valid hold. An outstanding request is not withdrawn.
- Flush (highest priority, beats stall):
  - IF/ID valid<=0, instr<=0, skid cleared, pc<=redirect_pc.
  - If imem_req=1 and ack=0: latch redirect_pc, go to DRAIN (the address must not change mid-request).
  - If ack=1 the same cycle: data is discarded and the next request goes to redirect_pc.
- Simultaneous flush+stall: flush wins; the bubble is written even though stall=1.
- PC wraps modulo 2^PC_W (0xFF+1 -> 0x00) with no error.
- imem_ack while imem_req=0 is ignored.
- Reset mid-request: everything returns to reset values immediately; any later ack is ignored because req=0.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[15:0] (instructions loaded valid into IF/ID) and stall_cnt[15:0] (cycles with stall=1 and ifid_valid=1). Both saturate at 0xFFFF and are cleared by reset.
- Undefined: the ports and logic are absent and the core behaviour is identical.

Decomposition:
- Shared package/include riscproc_pkg:
  - OPC_ALU=4'b0000, OPC_ST=4'b0001, OPC_ALUI=4'b0011, OPC_ALU2=4'b0111, used by both this stage and the decoder.
  - INSTR_W/PC_W defaults.
  - Fetch state encoding IDLE/FETCH/HOLD/DRAIN.
- One sub-module: if_skid_buf, a one-entry instr+pc buffer with load/unload/clear and full flag.

Test Plan:
- Zero-wait memory (ack same cycle as req), program at 0x00..0x03 = 0x0123, 0x1456, 0x3789, 0x7ABC -> opcode sequence 0,1,3,7 on consecutive cycles; ifid_pc 0..3; imem_addr advances one per cycle.
- Stall for 3 cycles during an ack at pc=0x05 -> IF/ID holds the pc=0x04 instruction; req=0 in HOLD; the 0x05 instruction appears the cycle stall drops; pc resumes at 0x06 with no instruction lost or duplicated.
- 2-wait-state memory, flush with redirect_pc=0x40 while the request to 0x10 is pending -> addr stays 0x10 until ack; that data is discarded; ifid_valid=0; next req addr=0x40.
- flush and stall asserted together -> ifid_valid=0 next cycle; skid empty; fetch restarts at redirect_pc.
- PC at 0xFF, zero-wait -> next imem_addr=0x00; ifid_pc goes 0xFF then 0x00.
- Assert rst_n=0 mid-request with ack arriving one cycle later -> all outputs at reset values immediately; late ack has no effect; first post-reset addr=RESET_PC. With IF_PERF_CNT_EN, counters read 0.
